// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit add/subtract, one 4-bit nibble
// per clock through a ripple slice whose carry is held in a register.
// Valid/ready handshake on the input and on the output side.
// Optional build macro ADDER_SATURATE_EN: when signed overflow occurs, Sum is
// clamped to max positive / min negative instead of wrapping.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = $clog2(NIB + 1);
  // k counts nibbles 0..NIB-1; k == KEND is the extra cycle that hands the
  // finished working sum over to the output registers.
  localparam logic [KW-1:0] KLAST = KW'(NIB - 1);
  localparam logic [KW-1:0] KEND  = KW'(NIB);
`ifdef ADDER_SATURATE_EN
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] opa, opb, wsum;
  logic             carry;   // running carry between nibbles
  logic             cmsb;    // carry into bit WIDTH-1
  logic [KW-1:0]    k;

  int         idx;
  logic [3:0] a_nib, b_nib, s_nib;
  logic       c_nib, c3_nib;
  logic [4:0] full;
  logic [3:0] low3;

  // Nibble slice: 4-bit add plus the carry out of its bit 2 (only used on
  // the top nibble to form the carry into the MSB).
  always_comb begin
    idx    = 4 * int'(k);
    a_nib  = 4'h0;
    b_nib  = 4'h0;
    if (k != KEND) begin
      a_nib = opa[idx +: 4];
      b_nib = opb[idx +: 4];
    end
    full   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry};
    low3   = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry};
    s_nib  = full[3:0];
    c_nib  = full[4];
    c3_nib = low3[3];
  end

  // Handshake flags decoded from the registered state; in_ready is masked
  // while reset is asserted.
  assign in_ready  = (state == IDLE) && Reset_n;
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)    state_nx = RUN;
      RUN:     if (k == KEND)   state_nx = DONE;
      DONE:    if (out_ready)   state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // Operand capture, nibble-serial accumulate and output load on DONE entry.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      opa      <= '0;
      opb      <= '0;
      wsum     <= '0;
      carry    <= 1'b0;
      cmsb     <= 1'b0;
      k        <= '0;
      Sum      <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opa   <= A;
          opb   <= Sub ? ~B : B;
          carry <= Sub | Cin;
          k     <= '0;
        end
        RUN: if (k != KEND) begin
          wsum[idx +: 4] <= s_nib;
          carry          <= c_nib;
          k              <= k + 1'b1;
          if (k == KLAST) cmsb <= c3_nib;
        end else begin
          Cout     <= carry;
          Overflow <= carry ^ cmsb;
`ifdef ADDER_SATURATE_EN
          if (carry ^ cmsb) Sum <= opa[WIDTH-1] ? MINN : MAXP;
          else              Sum <= wsum;
`else
          Sum      <= wsum;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
